q_update_pipe: RTL and testbench
================================

Name: q_update_pipe

Overview:
Pipelined, parametrised Q-value update engine for the Q-learning datapath. It computes the temporal-difference update new_q = old_q + ((rt + (max_q >>> gamma) − old_q) >>> alpha) on signed fixed-point values. It uses a 3-stage valid/ready pipeline, output saturation and a saturation-event counter. It sits between the Q-table read port and the Q-table write-back port, and accepts one update per cycle when not back-pressured.

Parameters:
DATA_W, 16, signed width of old_q, max_q, rt and new_q (two's complement, ≥4)
SHIFT_W, 4, width of the gamma/alpha shift-amount fields
ACCUMULATE, 1, 1 = add old_q back (full Q update); 0 = output the scaled TD term only (legacy behaviour)
CNT_W, 16, width of the saturation-event counter

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input transaction valid
in_ready  output  1  engine can accept input this cycle
old_q  input  DATA_W  current Q(s,a), signed
max_q  input  DATA_W  max over a' of Q(s',a'), signed
rt  input  DATA_W  reward, signed
gamma  input  SHIFT_W  discount as right-shift amount
alpha  input  SHIFT_W  learning rate as right-shift amount
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
new_q  output  DATA_W  updated Q, signed, saturated
sat  output  1  new_q was clipped (qualified by out_valid)
sat_count  output  CNT_W  number of saturated results delivered, sticks at all-ones
sat_clear  input  1  synchronous clear of sat_count

Behaviour:
- Reset (async assert, sync release): all stage valids = 0, out_valid = 0, new_q = 0, sat = 0, sat_count = 0. in_ready = 1 after reset. In-flight transactions are discarded; no partial output.
- Transfer occurs when valid && ready are both high on the same edge, at both the input and the output.
- Stage 1 (S1): register old_q, rt and alpha; compute sm = max_q >>> gamma. The shift is arithmetic (sign-filling, floor). Any shift ≥ DATA_W yields 0 or −1.
- Stage 2 (S2): td = rt + sm − old_q, computed in DATA_W+2 signed bits, no overflow possible. Register td, old_q and alpha.
- Stage 3 (S3): delta = td >>> alpha, arithmetic with floor (e.g. −7 >>> 1 = −4). res = ACCUMULATE ? old_q + delta : delta, computed in DATA_W+3 bits.
- Saturation: clip res to [−2^(DATA_W−1), 2^(DATA_W−1)−1]. sat = 1 iff clipped. new_q and sat are registered.
- Latency: 3 cycles from input acceptance to out_valid with no stall. Throughput is 1 per cycle.
- Back-pressure: each stage advances when its downstream slot is empty or being drained, i.e. ready_k = !valid_k || ready_{k+1}, with ready_out = out_ready. in_ready = ready of S1, a combinational chain from out_ready.
- While stalled, out_valid, new_q and sat hold stable until accepted. Results exit in input order; none are dropped or duplicated.
- Bubbles: a stage with valid = 0 is overwritten freely. Data registers of invalid stages are don't-care, but new_q must not change while out_valid = 1 and out_ready = 0.
- sat_count increments by 1 when an output transfer occurs with sat = 1. It saturates at 2^CNT_W − 1 and does not wrap.
- sat_clear sets sat_count to 0 the next cycle. If sat_clear and a counting event coincide, clear wins and the event is not counted.
- Simultaneous input accept and output drain in the same cycle with the pipe full is required to sustain full throughput.

Test Plan:
- Basic, DATA_W=16, ACCUMULATE=1: old_q=100, max_q=800, gamma=1, rt=50, alpha=2 → new_q=187 (td=350, delta=87) exactly 3 cycles after acceptance, sat=0.
- Negative/floor: old_q=1000, max_q=0, rt=0, gamma=0, alpha=1 → new_q=500. Then old_q=0, max_q=0, rt=−7, alpha=1 → new_q=−4.
- Saturation and counter: old_q=rt=max_q=32767, gamma=alpha=0 → new_q=32767, sat=1, sat_count=1. All three = −32768 → new_q=−32768, sat=1, sat_count=2. Assert sat_clear coincident with a third saturating output → sat_count=0.
- Streaming under back-pressure: 20 back-to-back random inputs, out_ready toggled pseudo-randomly. Results must match the reference model in order, with no loss or duplication, and new_q stable while stalled. With out_ready held high: one result per cycle.
- ACCUMULATE=0 build: old_q=100, max_q=800, gamma=1, rt=50, alpha=2 → new_q=87. Large shift: gamma=15, max_q=−1 → sm=−1.
- Reset mid-stream: assert rst_n low with 3 items in flight → out_valid=0, sat_count=0 immediately (async). After release, no stale result appears and the next input returns after 3 cycles.

Source files
------------

// File: rtl/q_update_pipe.sv
// q_update_pipe
//   Three-stage valid/ready Q-learning update engine:
//     new_q = sat(old_q + ((rt + (max_q >>> gamma) - old_q) >>> alpha))
//   With ACCUMULATE = 0 the old_q term is not added back and only the
//   scaled TD term is produced. A saturating counter tallies clipped
//   results as they are handed downstream.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   input handshake
//   old_q, max_q, rt      signed DATA_W operands
//   gamma, alpha          right-shift amounts (discount, learning rate)
//   out_valid / out_ready output handshake
//   new_q, sat            saturated result and clip flag (held while stalled)
//   sat_count, sat_clear  saturated-result counter (sticks at all-ones), sync clear
module q_update_pipe #(
   parameter int DATA_W     = 16,
   parameter int SHIFT_W    = 4,
   parameter int ACCUMULATE = 1,
   parameter int CNT_W      = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] old_q,
   input  logic signed [DATA_W-1:0] max_q,
   input  logic signed [DATA_W-1:0] rt,
   input  logic [SHIFT_W-1:0]       gamma,
   input  logic [SHIFT_W-1:0]       alpha,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] new_q,
   output logic                     sat,
   output logic [CNT_W-1:0]         sat_count,
   input  logic                     sat_clear
);

   localparam int TD_W  = DATA_W + 2;
   localparam int RES_W = DATA_W + 3;

   localparam logic signed [RES_W-1:0] Q_MAX = {{4{1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [RES_W-1:0] Q_MIN = {{4{1'b1}}, {(DATA_W-1){1'b0}}};

   // Stage 1 registers
   logic                     s1_valid;
   logic signed [DATA_W-1:0] s1_old;
   logic signed [DATA_W-1:0] s1_rt;
   logic signed [DATA_W-1:0] s1_sm;
   logic [SHIFT_W-1:0]       s1_alpha;

   // Stage 2 registers
   logic                     s2_valid;
   logic signed [TD_W-1:0]   s2_td;
   logic signed [DATA_W-1:0] s2_old;
   logic [SHIFT_W-1:0]       s2_alpha;

   logic s1_ready;
   logic s2_ready;
   logic s3_ready;

   logic signed [DATA_W-1:0] sm_next;
   logic signed [TD_W-1:0]   td_next;
   logic signed [TD_W-1:0]   delta;
   logic signed [RES_W-1:0]  res;
   logic signed [DATA_W-1:0] q_next;
   logic                     sat_next;

   // A stage may load when it is empty or its content moves on this edge;
   // the chain is combinational from out_ready so a full pipe still
   // accepts one item per cycle.
   assign s3_ready = !out_valid || out_ready;
   assign s2_ready = !s2_valid  || s3_ready;
   assign s1_ready = !s1_valid  || s2_ready;
   assign in_ready = s1_ready;

   always_comb begin
      sm_next  = max_q >>> gamma;
      td_next  = TD_W'(s1_rt) + TD_W'(s1_sm) - TD_W'(s1_old);
      delta    = s2_td >>> s2_alpha;
      if (ACCUMULATE != 0) begin
         res = RES_W'(s2_old) + RES_W'(delta);
      end else begin
         res = RES_W'(delta);
      end
      q_next   = res[DATA_W-1:0];
      sat_next = 1'b0;
      if (res > Q_MAX) begin
         q_next   = Q_MAX[DATA_W-1:0];
         sat_next = 1'b1;
      end else if (res < Q_MIN) begin
         q_next   = Q_MIN[DATA_W-1:0];
         sat_next = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_old    <= '0;
         s1_rt     <= '0;
         s1_sm     <= '0;
         s1_alpha  <= '0;
         s2_valid  <= 1'b0;
         s2_td     <= '0;
         s2_old    <= '0;
         s2_alpha  <= '0;
         out_valid <= 1'b0;
         new_q     <= '0;
         sat       <= 1'b0;
      end else begin
         if (s1_ready) begin
            s1_valid <= in_valid;
            s1_old   <= old_q;
            s1_rt    <= rt;
            s1_sm    <= sm_next;
            s1_alpha <= alpha;
         end
         if (s2_ready) begin
            s2_valid <= s1_valid;
            s2_td    <= td_next;
            s2_old   <= s1_old;
            s2_alpha <= s1_alpha;
         end
         if (s3_ready) begin
            out_valid <= s2_valid;
            // Result registers only move when a real item arrives.
            if (s2_valid) begin
               new_q <= q_next;
               sat   <= sat_next;
            end
         end
      end
   end

   // Clear has priority over a coincident counting event.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_count <= '0;
      end else if (sat_clear) begin
         sat_count <= '0;
      end else if (out_valid && out_ready && sat && (sat_count != '1)) begin
         sat_count <= sat_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_q_update_pipe.sv
module tb_q_update_pipe;

   localparam int DW = 16;
   localparam int SW = 4;
   localparam int CW = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic                 in_valid  = 1'b0;
   logic                 out_ready = 1'b1;
   logic                 sat_clear = 1'b0;
   logic signed [DW-1:0] old_q = '0;
   logic signed [DW-1:0] max_q = '0;
   logic signed [DW-1:0] rt    = '0;
   logic [SW-1:0]        gamma = '0;
   logic [SW-1:0]        alpha = '0;

   logic                 in_ready_a, out_valid_a, sat_a;
   logic signed [DW-1:0] new_q_a;
   logic [CW-1:0]        sat_count_a;
   logic                 in_ready_b, out_valid_b, sat_b;
   logic signed [DW-1:0] new_q_b;
   logic [CW-1:0]        sat_count_b;

   q_update_pipe #(.DATA_W(DW), .SHIFT_W(SW), .ACCUMULATE(1), .CNT_W(CW)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
      .old_q(old_q), .max_q(max_q), .rt(rt), .gamma(gamma), .alpha(alpha),
      .out_valid(out_valid_a), .out_ready(out_ready), .new_q(new_q_a), .sat(sat_a),
      .sat_count(sat_count_a), .sat_clear(sat_clear));

   q_update_pipe #(.DATA_W(DW), .SHIFT_W(SW), .ACCUMULATE(0), .CNT_W(CW)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
      .old_q(old_q), .max_q(max_q), .rt(rt), .gamma(gamma), .alpha(alpha),
      .out_valid(out_valid_b), .out_ready(out_ready), .new_q(new_q_b), .sat(sat_b),
      .sat_count(sat_count_b), .sat_clear(sat_clear));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual %0d required %0d", name, act, exp);
      end
   endtask

   // floor(x / 2^s)
   function automatic longint floor_shr(input longint x, input int unsigned s);
      longint d;
      longint q;
      d = longint'(1) << s;
      q = x / d;
      if ((x % d) != 0 && x < 0) q = q - 1;
      return q;
   endfunction

   function automatic void model(input longint o, input longint m, input longint r,
                                 input int unsigned g, input int unsigned a, input bit acc,
                                 output longint q, output bit s);
      longint td, d, res, hi, lo;
      hi  = (longint'(1) << (DW - 1)) - 1;
      lo  = -(longint'(1) << (DW - 1));
      td  = r + floor_shr(m, g) - o;
      d   = floor_shr(td, a);
      res = acc ? o + d : d;
      s   = 1'b0;
      q   = res;
      if (res > hi) begin q = hi; s = 1'b1; end
      if (res < lo) begin q = lo; s = 1'b1; end
   endfunction

   typedef struct {
      longint qa;
      bit     sa;
      longint qb;
      bit     sb;
   } exp_t;

   exp_t   sb_q[$];
   longint mcnt_a = 0;
   longint mcnt_b = 0;
   bit     prev_stall = 1'b0;
   logic signed [DW-1:0] prev_q = '0;
   logic   prev_sat = 1'b0;

   // Compare process: mid-cycle, inputs and outputs are stable until the next edge.
   always @(negedge clk) begin
      exp_t   e;
      longint cmax;
      bit     xa, xb;
      cmax = (longint'(1) << CW) - 1;
      if (!rst_n) begin
         sb_q.delete();
         mcnt_a = 0;
         mcnt_b = 0;
         prev_stall = 1'b0;
         chk("rst_out_valid", longint'(out_valid_a), 0);
         chk("rst_sat_count", longint'(sat_count_a), 0);
      end else begin
         chk("sat_count_a", longint'(sat_count_a), mcnt_a);
         chk("sat_count_b", longint'(sat_count_b), mcnt_b);
         if (out_ready) chk("in_ready_full_rate", longint'(in_ready_a), 1);
         if (prev_stall) begin
            chk("stall_valid_hold", longint'(out_valid_a), 1);
            chk("stall_q_hold", longint'(new_q_a), longint'(prev_q));
            chk("stall_sat_hold", longint'(sat_a), longint'(prev_sat));
         end
         xa = 1'b0;
         xb = 1'b0;
         if (!out_valid_a) chk("b_valid_idle", longint'(out_valid_b), 0);
         if (out_valid_a) begin
            if (sb_q.size() == 0) begin
               chk("spurious_output", longint'(out_valid_a), 0);
            end else if (out_ready) begin
               e = sb_q.pop_front();
               chk("new_q_a", longint'(new_q_a), e.qa);
               chk("sat_a", longint'(sat_a), longint'(e.sa));
               chk("b_valid", longint'(out_valid_b), 1);
               chk("new_q_b", longint'(new_q_b), e.qb);
               chk("sat_b", longint'(sat_b), longint'(e.sb));
               xa = e.sa;
               xb = e.sb;
            end
         end
         if (sat_clear) begin
            mcnt_a = 0;
            mcnt_b = 0;
         end else begin
            if (xa && mcnt_a < cmax) mcnt_a++;
            if (xb && mcnt_b < cmax) mcnt_b++;
         end
         if (in_valid && in_ready_a) begin
            model(longint'(old_q), longint'(max_q), longint'(rt), gamma, alpha, 1'b1, e.qa, e.sa);
            model(longint'(old_q), longint'(max_q), longint'(rt), gamma, alpha, 1'b0, e.qb, e.sb);
            sb_q.push_back(e);
         end
         prev_stall = out_valid_a && !out_ready;
         prev_q     = new_q_a;
         prev_sat   = sat_a;
      end
   end

   // Present one item and hold it until accepted; returns just after the accept edge.
   task automatic send(input int o, input int m, input int r, input int g, input int a);
      bit done;
      done     = 1'b0;
      old_q    = DW'(o);
      max_q    = DW'(m);
      rt       = DW'(r);
      gamma    = SW'(g);
      alpha    = SW'(a);
      in_valid = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (in_ready_a) begin
            @(posedge clk);
            #1;
            done = 1'b1;
         end
      end
      in_valid = 1'b0;
      if (!done) chk("send_timeout", 0, 1);
   endtask

   task automatic send_rand();
      send(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
           int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 15)),
           int'($urandom_range(0, 15)));
   endtask

   // Acceptance edge already passed: result must appear after exactly two more edges.
   task automatic expect_lat(input string name, input int qa, input int qb, input bit sa);
      @(posedge clk); #1;
      chk({name, "_early"}, longint'(out_valid_a), 0);
      @(posedge clk); #1;
      chk({name, "_valid"}, longint'(out_valid_a), 1);
      chk({name, "_q_acc"}, longint'(new_q_a), longint'(qa));
      chk({name, "_sat"}, longint'(sat_a), longint'(sa));
      chk({name, "_q_td"}, longint'(new_q_b), longint'(qb));
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(posedge clk);
      chk("drain_empty", longint'(sb_q.size()), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired actual running required finished");
      $fatal(1, "watchdog");
   end

   initial begin
      time t0;
      bit  stop;
      #1;
      chk("reset_out_valid", longint'(out_valid_a), 0);
      chk("reset_new_q", longint'(new_q_a), 0);
      chk("reset_sat", longint'(sat_a), 0);
      chk("reset_sat_count", longint'(sat_count_a), 0);
      chk("reset_in_ready", longint'(in_ready_a), 1);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;

      // Pinned literal cases
      send(100, 800, 50, 1, 2);        expect_lat("basic", 187, 87, 1'b0);
      send(1000, 0, 0, 0, 1);          expect_lat("floor_pos", 500, -500, 1'b0);
      send(0, 0, -7, 0, 1);            expect_lat("floor_neg", -4, -4, 1'b0);
      send(0, -1, 0, 15, 0);           expect_lat("big_shift", -1, -1, 1'b0);
      drain();

      send(32767, 32767, 32767, 0, 0);    expect_lat("sat_hi", 32767, 32767, 1'b1);
      @(posedge clk); #1;
      chk("sat_count_1", longint'(sat_count_a), 1);
      send(-32768, -32768, -32768, 0, 0); expect_lat("sat_lo", -32768, -32768, 1'b1);
      @(posedge clk); #1;
      chk("sat_count_2", longint'(sat_count_a), 2);
      send(32767, 32767, 32767, 0, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      sat_clear = 1'b1;
      @(posedge clk); #1;
      sat_clear = 1'b0;
      chk("sat_clear_wins", longint'(sat_count_a), 0);
      drain();

      // Random stream with random back-pressure
      stop = 1'b0;
      fork
         begin
            for (int n = 0; n < 20; n++) send_rand();
            stop = 1'b1;
         end
         begin
            while (!stop) begin
               @(posedge clk); #1;
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      out_ready = 1'b1;
      drain();

      // Full rate: back-to-back accepts, one per cycle
      t0 = $time;
      for (int n = 0; n < 10; n++) send_rand();
      chk("full_rate_cycles", longint'(($time - t0) / 10), 10);
      drain();

      // Reset with items in flight
      send(32767, 32767, 32767, 0, 0);
      drain();
      chk("pre_reset_count", longint'(sat_count_a), 1);
      for (int n = 0; n < 3; n++) send_rand();
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_valid", longint'(out_valid_a), 0);
      chk("async_rst_count", longint'(sat_count_a), 0);
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      for (int n = 0; n < 5; n++) begin
         @(posedge clk); #1;
         chk("no_stale_output", longint'(out_valid_a), 0);
      end
      send(100, 800, 50, 1, 2);        expect_lat("post_reset", 187, 87, 1'b0);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
